// File: rtl/apu_pkg.sv
// Shared definitions for the APU length counter bank: the 32-entry length
// table, its index width and the default channel count.
package apu_pkg;

    localparam int LEN_IDX_W        = 5;
    localparam int DEFAULT_CHANNELS = 4;

    localparam logic [7:0] LENGTH_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

endpackage

// File: rtl/length_counter_channel.sv
// One APU length counter: table load, gated decrement and a one-cycle expiry pulse.
// Define LENGTH_CLOCK_RACE_EN to let a running decrement beat a coincident load.
module length_counter_channel
    import apu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 half_frame,
    input  logic                 enable,
    input  logic                 halt,
    input  logic                 load,
    input  logic [LEN_IDX_W-1:0] load_index,
    output logic [CNT_W-1:0]     count,
    output logic                 active,
    output logic                 expired
);

`ifdef LENGTH_CLOCK_RACE_EN
    localparam bit RACE_EN = 1'b1;
`else
    localparam bit RACE_EN = 1'b0;
`endif

    logic [CNT_W-1:0] count_q, count_d;
    logic             active_q;
    logic             expired_q, expired_d;
    logic             tick;
    logic             load_wins;

    always_comb begin
        tick      = half_frame && !halt && (count_q != '0);
        // In the race build a live decrement swallows a coincident load.
        load_wins = load && !(RACE_EN && tick);
        count_d   = count_q;
        expired_d = 1'b0;
        if (!enable) begin
            count_d = '0;
        end else if (load_wins) begin
            count_d = CNT_W'(LENGTH_TABLE[load_index]);
        end else if (tick) begin
            count_d   = count_q - CNT_W'(1);
            expired_d = (count_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            active_q  <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            active_q  <= (count_d != '0);
            expired_q <= expired_d;
        end
    end

    assign count   = count_q;
    assign active  = active_q;
    assign expired = expired_q;

endmodule

// File: rtl/apu_length_counter_bank.sv
// Bank of independent APU length counters sharing one length table.
// Optional macro LENGTH_CLOCK_RACE_EN selects the hardware load/clock race behaviour.
module apu_length_counter_bank
    import apu_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          half_frame,
    input  logic [CHANNELS-1:0]           enable,
    input  logic [CHANNELS-1:0]           halt,
    input  logic [CHANNELS-1:0]           load,
    input  logic [CHANNELS*LEN_IDX_W-1:0] load_index,
    output logic [CHANNELS*CNT_W-1:0]     count,
    output logic [CHANNELS-1:0]           active,
    output logic [CHANNELS-1:0]           expired
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            length_counter_channel #(
                .CNT_W (CNT_W)
            ) u_channel (
                .clk        (clk),
                .reset      (reset),
                .half_frame (half_frame),
                .enable     (enable[gi]),
                .halt       (halt[gi]),
                .load       (load[gi]),
                .load_index (load_index[gi*LEN_IDX_W +: LEN_IDX_W]),
                .count      (count[gi*CNT_W +: CNT_W]),
                .active     (active[gi]),
                .expired    (expired[gi])
            );
        end
    endgenerate

endmodule

// File: doc/apu_length_counter_bank.md
# apu_length_counter_bank

Parametrised bank of APU length counters, one per sound channel, replacing the single fixed channel counter. Each channel loads an 8-bit length from the shared 32-entry length table on a register-write strobe and decrements on half-frame ticks from the frame sequencer. Channels can be individually enabled and halted. The bank reports per-channel count, a nonzero status for the status register and channel gating, and a one-cycle expiry pulse.

## Interface
- CHANNELS, 4, number of independent length counters (1..8)
- CNT_W, 8, counter width; must be ≥8 (table maximum 254)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- half_frame  in  1  one-cycle tick from frame sequencer
- enable  in  CHANNELS  per-channel enable (status-register bits)
- halt  in  CHANNELS  per-channel halt; freezes decrement
- load  in  CHANNELS  per-channel load strobe; any subset may assert together
- load_index  in  CHANNELS*5  per-channel table index, channel i at [5i+4:5i]
- count  out  CHANNELS*CNT_W  per-channel count, channel i at [CNT_W*i+CNT_W-1:CNT_W*i]
- active  out  CHANNELS  count != 0, registered
- expired  out  CHANNELS  one-cycle pulse on 1→0 decrement

## Operation
- Length table, index 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30. Zero-extend to CNT_W.
- Per-channel next-state priority, highest first:
  1. reset → 0
  2. !enable → 0; load is ignored.
  3. load & half_frame together → see Configuration.
  4. load → table[load_index]
  5. half_frame & !halt & count != 0 → count − 1
  6. otherwise hold
- No wrap-around: decrement is gated at 0, so the count never underflows.
- halt has no effect on loads. Deasserting halt resumes counting from the held value.
- Channels are fully independent. No shared state except the table.
- expired asserts in the cycle after the edge where count went 1→0 by decrement.
  - It does not fire for clears caused by reset or !enable.
  - It does not fire if the counter was already 0.

## Timing
- All outputs are registered. Reset values: count 0, active 0, expired 0.
- Load latency is 1 cycle: the loaded value is visible on count and active after the load edge.
- Decrement latency is 1 cycle after the half_frame edge.
- Reset asserted mid-count clears all channels on that edge. A load in the same cycle is discarded.
- Clearing enable zeroes the channel on the next edge and suppresses any in-flight load that cycle.
- half_frame held for N cycles decrements up to N times. The frame sequencer guarantees single-cycle pulses; this bank does not edge-detect.

## Configuration
- LENGTH_CLOCK_RACE_EN. This governs the case where load and half_frame (with !halt) coincide on an enabled channel.
- Defined (hardware-accurate quirk):
  - If the current count != 0, the load is ignored and count decrements.
  - If the current count == 0, the load takes effect (no decrement).
- Undefined: load always wins; no decrement that cycle.

## Structure
- Shared package apu_pkg holds:
  - the LENGTH_TABLE constant array (32×8)
  - LEN_IDX_W = 5
  - the default CHANNELS
- One sub-module, length_counter_channel: a single counter, its priority logic and the expired pulse.
- The bank instantiates length_counter_channel CHANNELS times via generate and slices the packed buses.

## Test plan
- Reset then load ch0 with index 20 → count0 = 48, active[0] = 1. Forty-eight half_frame pulses → count0 = 0, expired[0] pulses once on the final one, active[0] = 0.
- Load ch1 with index 1 (254), assert halt[1], apply 10 ticks → count1 holds 254. Release halt, apply 4 ticks → 250.
- Load ch2 with index 3 (2) and ch3 with index 8 (160) in the same cycle → count2 = 2 and count3 = 160 next cycle. Apply 3 ticks → count2 = 0 with one expired pulse, count3 = 157.
- ch0 at 5: drop enable[0] → count0 = 0, no expired pulse. Load with index 0 while disabled → stays 0.
- ch0 at 5, load index 0 coincident with half_frame:
  - with LENGTH_CLOCK_RACE_EN → 4
  - without → 10
  - At count 0 with the same stimulus → 10 in both builds.
- Assert reset mid-count with a simultaneous load on all channels → all count 0, active 0, expired 0 next cycle.
